// File: rtl/memory_arbiter_if.sv
// RAM-side types plus the bundled coherence / icache / RAM signals seen by memory_arbiter.
// The arbiter connects through the slave modport; the requester/RAM environment uses master.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface memory_arbiter_if #(parameter int CPUS = 2);
  import cpu_types_pkg::*;

  logic                   dREN;
  logic                   dWEN;
  logic [31:0]            daddr;
  logic [31:0]            dstore;
  logic                   dwait;
  logic [31:0]            dload;
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0][31:0]  iaddr;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0][31:0]  iload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [31:0]            ramaddr;
  logic [31:0]            ramstore;
  logic [31:0]            ramload;
  ramstate_t              ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between one coherence (data) port and CPUS icache ports.
// Define ARB_FAIRNESS_EN to force an icache grant after STARVE_LIMIT back-to-back data completions.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic            CLK,
  input logic            nRST,
  memory_arbiter_if.slave bus
);

  localparam int RRW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_ICACHE} owner_t;

  owner_t         owner_q, owner_d, cur_kind;
  logic [RRW-1:0] idx_q, idx_d, rr_q, rr_d, cur_idx, i_pick, scan;
  logic           i_found, data_req, done, starve_force;

  assign data_req  = bus.dREN | bus.dWEN;
  assign done      = (cur_kind != OWN_NONE) && (bus.ramstate == ACCESS);
  assign bus.dload = bus.ramload;
  assign bus.iload = {CPUS{bus.ramload}};

  // First requesting icache found by scanning upward from the round-robin pointer.
  always_comb begin
    i_found = 1'b0;
    i_pick  = '0;
    scan    = '0;
    for (int k = 0; k < CPUS; k++) begin
      scan = RRW'((int'(rr_q) + k) % CPUS);
      if (!i_found && bus.iREN[scan]) begin
        i_found = 1'b1;
        i_pick  = scan;
      end
    end
  end

  always_comb begin
    cur_kind     = OWN_NONE;
    cur_idx      = '0;
    owner_d      = owner_q;
    idx_d        = idx_q;
    rr_d         = rr_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dwait    = 1'b1;
    bus.iwait    = '1;

    if (nRST) begin
      if (owner_q == OWN_NONE) begin
        if (starve_force && i_found) begin
          cur_kind = OWN_ICACHE;
          cur_idx  = i_pick;
        end else if (data_req) begin
          cur_kind = OWN_DATA;
        end else if (i_found) begin
          cur_kind = OWN_ICACHE;
          cur_idx  = i_pick;
        end
      end else if (owner_q == OWN_DATA) begin
        if (data_req) cur_kind = OWN_DATA;
      end else if (bus.iREN[idx_q]) begin
        cur_kind = OWN_ICACHE;
        cur_idx  = idx_q;
      end
    end

    case (cur_kind)
      OWN_DATA: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (done) bus.dwait = 1'b0;
      end
      OWN_ICACHE: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[cur_idx];
        if (done) bus.iwait[cur_idx] = 1'b0;
      end
      default: ;
    endcase

    // A completed or abandoned request frees the RAM so the next cycle re-arbitrates.
    if (cur_kind == OWN_NONE || done) begin
      owner_d = OWN_NONE;
    end else begin
      owner_d = cur_kind;
      idx_d   = cur_idx;
    end
    if (done && cur_kind == OWN_ICACHE) begin
      rr_d = (cur_idx == RRW'(CPUS - 1)) ? '0 : cur_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner_q <= OWN_NONE;
      idx_q   <= '0;
      rr_q    <= '0;
    end else begin
      owner_q <= owner_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
    end
  end

`ifdef ARB_FAIRNESS_EN
  localparam int CNTW = $clog2(STARVE_LIMIT + 1);

  logic [CNTW-1:0] starve_cnt;

  // Counts data completions that happened while some icache was kept waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (bus.iREN == '0 || (done && cur_kind == OWN_ICACHE)) begin
      starve_cnt <= '0;
    end else if (done && cur_kind == OWN_DATA && starve_cnt != CNTW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve_force = (starve_cnt == CNTW'(STARVE_LIMIT));
`else
  assign starve_force = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a per-cycle reference model plus directed literal checks.
// Build with ARB_FAIRNESS_EN defined to check the starvation-limit behaviour instead of strict priority.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS     = 2;
  localparam int LIMIT    = 4;
  localparam int NO_OWN   = -1;
  localparam int DATA_OWN = -2;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int m_owner = NO_OWN;
  int m_rr    = 0;
  int m_cnt   = 0;

  memory_arbiter_if #(.CPUS(CPUS)) bus ();

  memory_arbiter #(.CPUS(CPUS), .STARVE_LIMIT(LIMIT)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int firstIcache(input logic [CPUS-1:0] req, input int from);
    for (int k = 0; k < CPUS; k++) begin
      if (req[(from + k) % CPUS]) return (from + k) % CPUS;
    end
    return NO_OWN;
  endfunction

  // Reference model: decides who owns the RAM this cycle from the arbitration rules, then advances.
  always @(negedge CLK) begin : scoreboard
    int              act;
    bit              acc;
    logic            e_ren, e_wen, e_dwait;
    logic [31:0]     e_addr, e_store;
    logic [CPUS-1:0] e_iwait;

    act = NO_OWN;
    acc = (bus.ramstate == ACCESS);
    if (nRST) begin
      if (m_owner == NO_OWN) begin
        if (FAIR && m_cnt >= LIMIT && bus.iREN != '0) act = firstIcache(bus.iREN, m_rr);
        else if (bus.dREN || bus.dWEN)                 act = DATA_OWN;
        else                                           act = firstIcache(bus.iREN, m_rr);
      end else if (m_owner == DATA_OWN) begin
        act = (bus.dREN || bus.dWEN) ? DATA_OWN : NO_OWN;
      end else begin
        act = bus.iREN[m_owner] ? m_owner : NO_OWN;
      end
    end

    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_dwait = 1'b1; e_iwait = '1;
    if (act == DATA_OWN) begin
      e_wen   = bus.dWEN;
      e_ren   = bus.dREN && !bus.dWEN;
      e_addr  = bus.daddr;
      e_store = bus.dstore;
      e_dwait = !acc;
    end else if (act >= 0) begin
      e_ren        = 1'b1;
      e_addr       = bus.iaddr[act];
      e_iwait[act] = !acc;
    end

    checkOutput("cmp_ramREN", 32'(bus.ramREN), 32'(e_ren));
    checkOutput("cmp_ramWEN", 32'(bus.ramWEN), 32'(e_wen));
    checkOutput("cmp_ramaddr", bus.ramaddr, e_addr);
    checkOutput("cmp_ramstore", bus.ramstore, e_store);
    checkOutput("cmp_dwait", 32'(bus.dwait), 32'(e_dwait));
    checkOutput("cmp_iwait", 32'(bus.iwait), 32'(e_iwait));
    checkOutput("cmp_dload", bus.dload, bus.ramload);
    for (int i = 0; i < CPUS; i++) checkOutput("cmp_iload", bus.iload[i], bus.ramload);

    if (!nRST) begin
      m_owner = NO_OWN;
      m_rr    = 0;
      m_cnt   = 0;
    end else begin
      if (FAIR) begin
        if (bus.iREN == '0 || (act >= 0 && acc))             m_cnt = 0;
        else if (act == DATA_OWN && acc && m_cnt < LIMIT)  m_cnt++;
      end
      if (act == NO_OWN || acc) begin
        m_owner = NO_OWN;
        if (act >= 0 && acc) m_rr = (act + 1) % CPUS;
      end else begin
        m_owner = act;
      end
    end
  end

  task automatic applyStimulus(input logic dren, input logic dwen, input logic [31:0] da,
                               input logic [31:0] ds, input logic [CPUS-1:0] iren, input ramstate_t rs);
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.iREN     = iren;
    bus.ramstate = rs;
    bus.ramload  = $urandom;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic expectCycle(input string tag, input logic ren, input logic wen, input logic [31:0] addr,
                             input logic dw, input logic [CPUS-1:0] iw);
    @(negedge CLK);
    checkOutput({tag, ".ramREN"}, 32'(bus.ramREN), 32'(ren));
    checkOutput({tag, ".ramWEN"}, 32'(bus.ramWEN), 32'(wen));
    checkOutput({tag, ".ramaddr"}, bus.ramaddr, addr);
    checkOutput({tag, ".dwait"}, 32'(bus.dwait), 32'(dw));
    checkOutput({tag, ".iwait"}, 32'(bus.iwait), 32'(iw));
    nextCycle();
  endtask

  task automatic doReset(input string tag);
    nRST = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, FREE);
    @(negedge CLK);
    checkOutput({tag, ".ramstore"}, bus.ramstore, 32'h0);
    nextCycle();
    expectCycle({tag, ".held"}, 1'b0, 1'b0, 32'h0, 1'b1, 2'b11);
    nRST = 1'b1;
    expectCycle({tag, ".after"}, 1'b0, 1'b0, 32'h0, 1'b1, 2'b11);
  endtask

  logic [31:0]     starve_addr [6];
  logic [CPUS-1:0] starve_iw   [6];
  ramstate_t       rs;

  initial begin
    bus.iaddr[0] = 32'h0000_2000;
    bus.iaddr[1] = 32'h0000_3000;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, FREE);
    nextCycle();
    doReset("rst0");

    // Data beats icache, icache follows on the next cycle.
    applyStimulus(1'b1, 1'b0, 32'h100, '0, 2'b01, ACCESS);
    expectCycle("prio0", 1'b1, 1'b0, 32'h100, 1'b0, 2'b11);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b01, ACCESS);
    expectCycle("prio1", 1'b1, 1'b0, 32'h2000, 1'b1, 2'b10);

    // Write with three wait states (one reported as ERROR).
    doReset("rst1");
    for (int c = 0; c < 4; c++) begin
      if (c == 3)      rs = ACCESS;
      else if (c == 1) rs = ERROR;
      else             rs = BUSY;
      applyStimulus(1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, '0, rs);
      @(negedge CLK);
      checkOutput("ws.ramstore", bus.ramstore, 32'hCAFE_F00D);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, '0, BUSY);
    expectCycle("ws.rearb", 1'b0, 1'b1, 32'h44, 1'b1, 2'b11);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, ACCESS);
    expectCycle("ws.idle", 1'b0, 1'b0, 32'h0, 1'b1, 2'b11);

    // Round robin between two icaches.
    doReset("rst2");
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b11, ACCESS);
    expectCycle("rr0", 1'b1, 1'b0, 32'h2000, 1'b1, 2'b10);
    expectCycle("rr1", 1'b1, 1'b0, 32'h3000, 1'b1, 2'b01);
    expectCycle("rr2", 1'b1, 1'b0, 32'h2000, 1'b1, 2'b10);
    expectCycle("rr3", 1'b1, 1'b0, 32'h3000, 1'b1, 2'b01);

    // Reset while I1 is waiting on a busy RAM.
    doReset("rst3");
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b10, BUSY);
    expectCycle("mid0", 1'b1, 1'b0, 32'h3000, 1'b1, 2'b11);
    expectCycle("mid1", 1'b1, 1'b0, 32'h3000, 1'b1, 2'b11);
    nRST = 1'b0;
    expectCycle("mid_low", 1'b0, 1'b0, 32'h0, 1'b1, 2'b11);
    nRST = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b11, ACCESS);
    expectCycle("mid_after", 1'b1, 1'b0, 32'h2000, 1'b1, 2'b10);

    // Owner drops its request before ACCESS.
    doReset("rst4");
    applyStimulus(1'b1, 1'b0, 32'h80, '0, '0, BUSY);
    expectCycle("drop0", 1'b1, 1'b0, 32'h80, 1'b1, 2'b11);
    applyStimulus(1'b0, 1'b0, 32'h80, '0, 2'b01, BUSY);
    expectCycle("drop1", 1'b0, 1'b0, 32'h0, 1'b1, 2'b11);
    expectCycle("drop2", 1'b1, 1'b0, 32'h2000, 1'b1, 2'b11);

    // Read and write together: write wins for the whole transaction.
    doReset("rst5");
    applyStimulus(1'b1, 1'b1, 32'h60, 32'h1234, '0, BUSY);
    expectCycle("both0", 1'b0, 1'b1, 32'h60, 1'b1, 2'b11);
    applyStimulus(1'b1, 1'b1, 32'h60, 32'h1234, '0, ACCESS);
    expectCycle("both1", 1'b0, 1'b1, 32'h60, 1'b0, 2'b11);

    // Data and I0 both held: only the fairness build ever lets I0 in.
    doReset("rst6");
    for (int c = 0; c < 6; c++) begin
      starve_addr[c] = 32'h100;
      starve_iw[c]   = 2'b11;
    end
    if (FAIR) begin
      starve_addr[4] = 32'h2000;
      starve_iw[4]   = 2'b10;
    end
    applyStimulus(1'b1, 1'b0, 32'h100, '0, 2'b01, ACCESS);
    for (int c = 0; c < 6; c++) begin
      expectCycle($sformatf("starve%0d", c), 1'b1, 1'b0, starve_addr[c],
                  (starve_addr[c] == 32'h100) ? 1'b0 : 1'b1, starve_iw[c]);
    end

    doReset("rst7");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
